// File: rtl/pmu_seq.sv
// pmu_seq: sequences CPU power-level / power-mode requests to the power manager.
// The UART is first held off and drained, then a one-cycle change pulse is
// issued, and the sequencer then settles for a fixed time before the next
// request runs.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no request active; accept a new one (or a parked pending one)
// DRAIN  | uart_hold high; wait for 2 idle UART samples or timeout
// APPLY  | one cycle: level_flag or mode_flag pulse, current value updated
// SETTLE | hold-off for SETTLE_CYCLES cycles before IDLE or next request
//
// Ports:
//   clock, rstb        single clock, async active-low reset
//   req_valid/req_data CPU write strobe + request byte
//                      (bit7=1: mode=bit0, bit7=0: level=bits[2:0])
//   uart_busy          UART transmitter / crossing busy
//   status_clr         clears sticky err_timeout and overrun
//   uart_hold          blocks new UART transmits while sequencing
//   level_flag/level   change-level pulse and last applied level
//   mode_flag/mode     change-mode pulse and last applied mode
//   req_busy           high whenever not IDLE
//   status             {req_busy, pend_valid, err_timeout, overrun,
//                       cur_mode, cur_level[2:0]}
module pmu_seq #(
  parameter logic [15:0] DRAIN_TIMEOUT = 16'd60000,
  parameter logic [7:0]  SETTLE_CYCLES = 8'd8
) (
  input  logic       clock,
  input  logic       rstb,
  input  logic       req_valid,
  input  logic [7:0] req_data,
  input  logic       uart_busy,
  input  logic       status_clr,
  output logic       uart_hold,
  output logic       level_flag,
  output logic       mode_flag,
  output logic [2:0] level,
  output logic       mode,
  output logic       req_busy,
  output logic [7:0] status
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAIN  = 2'd1,
    S_APPLY  = 2'd2,
    S_SETTLE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  act_q, act_d;
  logic [7:0]  pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;
  logic        err_q, err_d;
  logic        ovr_q, ovr_d;
  logic [15:0] tmo_q, tmo_d;
  logic        run_q, run_d;
  logic [7:0]  settle_q, settle_d;
  logic [2:0]  cur_level_q, cur_level_d;
  logic        cur_mode_q, cur_mode_d;
  logic        level_flag_q, level_flag_d;
  logic        mode_flag_q, mode_flag_d;
  logic        hold_q, busy_q;

  logic dup_req, dup_pend;
  logic enter_drain, go_apply, consume, take_direct, err_set, ovr_set;

  // A level request matching the current level is a no-op; mode requests
  // are always applied.
  assign dup_req  = !req_data[7] && (req_data[2:0] == cur_level_q);
  assign dup_pend = !pend_q[7] && (pend_q[2:0] == cur_level_q);

  always_comb begin
    state_d      = state_q;
    act_d        = act_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    tmo_d        = tmo_q;
    run_d        = run_q;
    settle_d     = settle_q;
    cur_level_d  = cur_level_q;
    cur_mode_d   = cur_mode_q;
    level_flag_d = 1'b0;
    mode_flag_d  = 1'b0;
    enter_drain  = 1'b0;
    go_apply     = 1'b0;
    consume      = 1'b0;
    take_direct  = 1'b0;
    err_set      = 1'b0;
    ovr_set      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A request parked during the final SETTLE cycle is served first.
        if (pend_valid_q) begin
          consume = 1'b1;
          if (!dup_pend) begin
            act_d       = pend_q;
            enter_drain = 1'b1;
          end
        end else if (req_valid) begin
          take_direct = 1'b1;
          if (!dup_req) begin
            act_d       = req_data;
            enter_drain = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (!uart_busy && run_q) begin
          go_apply = 1'b1;
        end else if (tmo_q == '0) begin
          go_apply = 1'b1;
          err_set  = 1'b1;
        end else begin
          tmo_d = tmo_q - 16'd1;
          run_d = !uart_busy;
        end
      end
      S_APPLY: begin
        state_d  = S_SETTLE;
        settle_d = SETTLE_CYCLES - 8'd1;
      end
      S_SETTLE: begin
        if (settle_q == '0) begin
          state_d = S_IDLE;
          if (pend_valid_q) begin
            consume = 1'b1;
            if (!dup_pend) begin
              act_d       = pend_q;
              enter_drain = 1'b1;
            end
          end
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_drain) begin
      state_d = S_DRAIN;
      tmo_d   = DRAIN_TIMEOUT - 16'd1;
      run_d   = 1'b0;
    end

    if (go_apply) begin
      state_d = S_APPLY;
      if (act_q[7]) begin
        mode_flag_d = 1'b1;
        cur_mode_d  = act_q[0];
      end else begin
        level_flag_d = 1'b1;
        cur_level_d  = act_q[2:0];
      end
    end

    if (consume) pend_valid_d = 1'b0;

    // Any request not taken directly from IDLE is parked. Overwriting a
    // pending request that is not being consumed this cycle is an overrun.
    if (req_valid && !take_direct) begin
      pend_d       = req_data;
      pend_valid_d = 1'b1;
      if (pend_valid_q && !consume) ovr_set = 1'b1;
    end

    // Set events win over a simultaneous clear.
    err_d = err_set | (err_q & ~status_clr);
    ovr_d = ovr_set | (ovr_q & ~status_clr);
  end

  always_ff @(posedge clock or negedge rstb) begin
    if (!rstb) begin
      state_q      <= S_IDLE;
      act_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      err_q        <= 1'b0;
      ovr_q        <= 1'b0;
      tmo_q        <= '0;
      run_q        <= 1'b0;
      settle_q     <= '0;
      cur_level_q  <= '0;
      cur_mode_q   <= 1'b0;
      level_flag_q <= 1'b0;
      mode_flag_q  <= 1'b0;
      hold_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_q        <= act_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      err_q        <= err_d;
      ovr_q        <= ovr_d;
      tmo_q        <= tmo_d;
      run_q        <= run_d;
      settle_q     <= settle_d;
      cur_level_q  <= cur_level_d;
      cur_mode_q   <= cur_mode_d;
      level_flag_q <= level_flag_d;
      mode_flag_q  <= mode_flag_d;
      hold_q       <= (state_d != S_IDLE);
      busy_q       <= (state_d != S_IDLE);
    end
  end

  assign uart_hold  = hold_q;
  assign req_busy   = busy_q;
  assign level_flag = level_flag_q;
  assign mode_flag  = mode_flag_q;
  assign level      = cur_level_q;
  assign mode       = cur_mode_q;
  assign status     = {busy_q, pend_valid_q, err_q, ovr_q, cur_mode_q, cur_level_q};

endmodule
